// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock mode controller: state encoding,
// time-word field positions, BCD limits and the state-to-LED mapping.
package clock_pkg;

  localparam int unsigned TIME_W  = 22;
  localparam int unsigned ALARM_W = 16;
  localparam int unsigned LED_W   = 5;

  // Bit positions inside the 22-bit BCD time word
  localparam int unsigned SEC_MSB = 7;
  localparam int unsigned MIN_LSB = 8;
  localparam int unsigned MIN_MSB = 14;
  localparam int unsigned HR_LSB  = 16;
  localparam int unsigned HR_MSB  = 21;

  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef enum logic [2:0] {
    ST_CLOCK     = 3'd0,
    ST_ADJ_T_MIN = 3'd1,
    ST_ADJ_T_HR  = 3'd2,
    ST_ADJ_A_MIN = 3'd3,
    ST_ADJ_A_HR  = 3'd4,
    ST_RING      = 3'd5
  } state_e;

  // RING shares the CLOCK lamp; alarm_ring already signals the ringing
  function automatic logic [LED_W-1:0] state_led(input state_e s);
    case (s)
      ST_ADJ_T_MIN: return 5'b00010;
      ST_ADJ_T_HR:  return 5'b00100;
      ST_ADJ_A_MIN: return 5'b01000;
      ST_ADJ_A_HR:  return 5'b10000;
      default:      return 5'b00001;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_bcd_field_step.sv
// Two-digit BCD +/-1 with wrap between 00 and a BCD maximum.
module bcd_field_step (
  input  logic [7:0] val_i,
  input  logic       up_i,
  input  logic [7:0] max_i,
  output logic [7:0] val_o
);

  logic [3:0] ones;
  logic [3:0] tens;

  assign ones = val_i[3:0];
  assign tens = val_i[7:4];

  always_comb begin
    val_o = val_i;
    if (up_i) begin
      if (val_i == max_i)     val_o = 8'h00;
      else if (ones == 4'd9)  val_o = {tens + 4'd1, 4'd0};
      else                    val_o = {tens, ones + 4'd1};
    end else begin
      if (val_i == 8'h00)     val_o = max_i;
      else if (ones == 4'd0)  val_o = {tens - 4'd1, 4'd9};
      else                    val_o = {tens, ones - 4'd1};
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm clock mode controller: sequences the counter chain between counting
// and adjust, owns the alarm register, match detection and ringing.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECONDS = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 btn_mode,
  input  logic                 btn_next,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 alarm_en,
  input  logic [TIME_W-1:0]    count,
  output logic                 clk_en,
  output logic                 clk_load,
  output logic [TIME_W-1:0]    clk_in_count,
  output logic [1:0]           clk_en_time,
  output logic [ALARM_W-1:0]   alarm_time,
  output logic                 alarm_ring,
  output logic [LED_W-1:0]     mode_led
);

  localparam int unsigned RING_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;

  state_e               state_q, state_d;
  logic [ALARM_W-1:0]   alarm_time_q, alarm_time_d;
  logic                 clk_load_q, clk_load_d;
  logic [TIME_W-1:0]    clk_in_count_q, clk_in_count_d;
  logic [1:0]           en_time_q, en_time_d;
  logic                 ring_q, ring_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [RING_W-1:0]    ring_cnt_q, ring_cnt_d;
  logic                 match_q, match_d;

  logic [7:0]           min_in, hr_in, min_step, hr_step;
  logic                 btn_any, step_req, match_rise;
  logic [TIME_W-1:0]    adj_word;

  // One stepper per field, shared by the time and alarm adjust paths
  assign min_in = (state_q == ST_ADJ_A_MIN) ? alarm_time_q[7:0]
                                            : count[MIN_MSB+1:MIN_LSB];
  assign hr_in  = (state_q == ST_ADJ_A_HR)  ? alarm_time_q[15:8]
                                            : {2'b00, count[HR_MSB:HR_LSB]};

  bcd_field_step u_min_step (
    .val_i (min_in),
    .up_i  (btn_up),
    .max_i (MIN_MAX),
    .val_o (min_step)
  );

  bcd_field_step u_hr_step (
    .val_i (hr_in),
    .up_i  (btn_up),
    .max_i (HR_MAX),
    .val_o (hr_step)
  );

  assign btn_any  = btn_mode | btn_next | btn_up | btn_down;
  assign step_req = btn_up | btn_down;

  // Match condition excludes state so that returning to CLOCK mid-match is no edge
  assign match_d    = alarm_en && (count[SEC_MSB:0] == 8'h00) &&
                      (alarm_time_q == {2'b00, count[HR_MSB:HR_LSB], count[MIN_MSB+1:MIN_LSB]});
  assign match_rise = match_d & ~match_q;

  assign clk_en = tick_1hz & ((state_q == ST_CLOCK) | (state_q == ST_RING));

  always_comb begin
    state_d        = state_q;
    alarm_time_d   = alarm_time_q;
    clk_load_d     = 1'b0;
    clk_in_count_d = clk_in_count_q;
    ring_cnt_d     = '0;
    adj_word       = '0;
    adj_word[HR_MSB:HR_LSB]   = count[HR_MSB:HR_LSB];
    adj_word[MIN_MSB:MIN_LSB] = count[MIN_MSB:MIN_LSB];

    unique case (state_q)
      ST_CLOCK: begin
        if (btn_mode)        state_d = ST_ADJ_T_MIN;
        else if (match_rise) state_d = ST_RING;
      end
      ST_ADJ_T_MIN: begin
        if (btn_mode)      state_d = ST_CLOCK;
        else if (btn_next) state_d = ST_ADJ_T_HR;
        else if (step_req) begin
          adj_word[MIN_MSB:MIN_LSB] = min_step[6:0];
          clk_in_count_d = adj_word;
          clk_load_d     = 1'b1;
        end
      end
      ST_ADJ_T_HR: begin
        if (btn_mode)      state_d = ST_CLOCK;
        else if (btn_next) state_d = ST_ADJ_A_MIN;
        else if (step_req) begin
          adj_word[HR_MSB:HR_LSB] = hr_step[5:0];
          clk_in_count_d = adj_word;
          clk_load_d     = 1'b1;
        end
      end
      ST_ADJ_A_MIN: begin
        if (btn_mode)      state_d = ST_CLOCK;
        else if (btn_next) state_d = ST_ADJ_A_HR;
        else if (step_req) alarm_time_d[7:0] = min_step;
      end
      ST_ADJ_A_HR: begin
        if (btn_mode)      state_d = ST_CLOCK;
        else if (btn_next) state_d = ST_ADJ_T_MIN;
        else if (step_req) alarm_time_d[15:8] = hr_step;
      end
      ST_RING: begin
        // Buttons here only silence the alarm
        if (btn_any || !alarm_en) state_d = ST_CLOCK;
        else if (tick_1hz) begin
          if (ring_cnt_q == RING_W'(RING_SECONDS - 1)) state_d = ST_CLOCK;
          else ring_cnt_d = ring_cnt_q + RING_W'(1);
        end else begin
          ring_cnt_d = ring_cnt_q;
        end
      end
      default: state_d = ST_CLOCK;
    endcase

    en_time_d = (state_d == ST_ADJ_T_MIN) ? 2'b01 :
                (state_d == ST_ADJ_T_HR)  ? 2'b10 : 2'b00;
    ring_d    = (state_d == ST_RING);
    led_d     = state_led(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CLOCK;
      alarm_time_q   <= '0;
      clk_load_q     <= 1'b0;
      clk_in_count_q <= '0;
      en_time_q      <= 2'b00;
      ring_q         <= 1'b0;
      led_q          <= 5'b00001;
      ring_cnt_q     <= '0;
      match_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      alarm_time_q   <= alarm_time_d;
      clk_load_q     <= clk_load_d;
      clk_in_count_q <= clk_in_count_d;
      en_time_q      <= en_time_d;
      ring_q         <= ring_d;
      led_q          <= led_d;
      ring_cnt_q     <= ring_cnt_d;
      match_q        <= match_d;
    end
  end

  assign clk_load     = clk_load_q;
  assign clk_in_count = clk_in_count_q;
  assign clk_en_time  = en_time_q;
  assign alarm_time   = alarm_time_q;
  assign alarm_ring   = ring_q;
  assign mode_led     = led_q;

endmodule
